// File: rtl/secded_pkg.sv
// ---------------------------------------------------------------------------
// secded_pkg : Hsiao SEC-DED column generation shared by encoder and decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package secded_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_CHK_W  = 8;

  // Smallest r with 2^(r-1) >= k + r; scanning downward leaves the smallest.
  function automatic int chk_w(input int k);
    int r;
    r = MAX_CHK_W;
    for (int c = MAX_CHK_W; c >= 2; c--) begin
      if ((1 << (c - 1)) >= k + c) r = c;
    end
    return r;
  endfunction

  function automatic int popcnt8(input int v);
    int n;
    n = 0;
    for (int b = 0; b < 8; b++) n += (v >> b) & 1;
    return n;
  endfunction

  // Column i of H: weight-3 values ascending, then weight 5, then weight 7.
  function automatic logic [7:0] hsiao_col(input int k, input int r, input int i);
    logic [7:0] col;
    int         n;
    col = '0;
    n   = 0;
    if (i < k) begin
      for (int w = 3; w <= 7; w += 2) begin
        for (int v = 0; v < (1 << r); v++) begin
          if (popcnt8(v) == w) begin
            if (n == i) col = 8'(v);
            n++;
          end
        end
      end
    end
    return col;
  endfunction

  // Row j of H over the data bits, built in one enumeration pass.
  function automatic logic [MAX_DATA_W-1:0] row_mask(input int k, input int r, input int j);
    logic [MAX_DATA_W-1:0] m;
    int                    n;
    m = '0;
    n = 0;
    for (int w = 3; w <= 7; w += 2) begin
      for (int v = 0; v < (1 << r); v++) begin
        if (popcnt8(v) == w) begin
          if (n < k && ((v >> j) & 1) == 1) m[n] = 1'b1;
          n++;
        end
      end
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/secded_skid.sv
// ---------------------------------------------------------------------------
// secded_skid : 2-entry in-order valid/ready skid buffer, registered handshakes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module secded_skid
  import secded_pkg::*;
#(
  parameter int WIDTH = 39
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  skid_state_e      state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;

  logic push;
  logic pop;

  assign push = in_valid_i & in_ready_q;
  assign pop  = out_valid_q & out_ready_i;

  // head_q is always the presented word; tail_q only holds data in FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SKID_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      in_ready_q <= 1'b1;
      case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            head_q      <= in_data_i;
            out_valid_q <= 1'b1;
            state_q     <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          case ({push, pop})
            2'b10: begin
              tail_q     <= in_data_i;
              in_ready_q <= 1'b0;
              state_q    <= SKID_FULL;
            end
            2'b01: begin
              out_valid_q <= 1'b0;
              state_q     <= SKID_EMPTY;
            end
            2'b11: head_q <= in_data_i;
            default: ;
          endcase
        end
        SKID_FULL: begin
          if (pop) begin
            head_q  <= tail_q;
            state_q <= SKID_ONE;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= SKID_EMPTY;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = head_q;

endmodule

`default_nettype wire

// File: rtl/secded_enc_pipe.sv
// ---------------------------------------------------------------------------
// secded_enc_pipe : parametrised Hsiao SEC-DED encoder behind a skid buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module secded_enc_pipe
  import secded_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  bit INJ_EN = 1'b0,
  localparam int CHK_W  = chk_w(DATA_W),
  localparam int CODE_W = DATA_W + CHK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CODE_W-1:0] in_inj,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [15:0]       word_cnt
);

  if (DATA_W < 8 || DATA_W > MAX_DATA_W) begin : g_param_chk
    $error("secded_enc_pipe: DATA_W must be within 8..64");
  end

  logic [CHK_W-1:0]  chk;
  logic [CODE_W-1:0] code_d;
  logic [15:0]       word_cnt_q;
  logic [15:0]       word_cnt_d;

  // One flat XOR reduction per check bit, masked by its row of H.
  for (genvar j = 0; j < CHK_W; j++) begin : g_chk
    localparam logic [MAX_DATA_W-1:0] c_row = row_mask(DATA_W, CHK_W, j);
    assign chk[j] = ^(in_data & c_row[DATA_W-1:0]);
  end

  if (INJ_EN) begin : g_inj
    assign code_d = {chk, in_data} ^ in_inj;
  end else begin : g_no_inj
    logic unused_inj;
    assign unused_inj = ^in_inj;
    assign code_d     = {chk, in_data};
  end

  secded_skid #(
    .WIDTH (CODE_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (code_d),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_code)
  );

  assign word_cnt_d = (out_valid && out_ready && word_cnt_q != 16'hFFFF)
                    ? word_cnt_q + 16'd1 : word_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_cnt_q <= '0;
    else        word_cnt_q <= word_cnt_d;
  end

  assign word_cnt = word_cnt_q;

endmodule

`default_nettype wire
